// File: rtl/vedic_mul16_sequencer_if.sv
// Operand/result handshake bundle for vedic_mul16_sequencer.
// The master side issues operands and consumes products; the slave side is the multiplier.
interface vedic_mul16_sequencer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                      clear;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     a;
  logic [DATA_WIDTH-1:0]     b;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*DATA_WIDTH-1:0]   product;
  logic                      busy;

  modport master (
    output clear, in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  clear, in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/vedic_mul16_sequencer.sv
// Area-lean 16x16 unsigned multiplier: one Vedic 8x8 core is reused over four cycles,
// one partial product per cycle, shift-accumulated into a 32-bit result.

module vedic_8_x_8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  // Urdhva-tiryagbhyam 2x2 cell: AND gates plus half adders, no '*' operator.
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic c;
    c = x[1] & y[0] & x[0] & y[1];
    return {x[1] & y[1] & c, (x[1] & y[1]) ^ c, (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
  endfunction

  function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
    return 8'(vedic2(x[1:0], y[1:0]))
         + (8'(vedic2(x[3:2], y[1:0])) << 2)
         + (8'(vedic2(x[1:0], y[3:2])) << 2)
         + (8'(vedic2(x[3:2], y[3:2])) << 4);
  endfunction

  assign p_o = 16'(vedic4(a_i[3:0], b_i[3:0]))
             + (16'(vedic4(a_i[7:4], b_i[3:0])) << 4)
             + (16'(vedic4(a_i[3:0], b_i[7:4])) << 4)
             + (16'(vedic4(a_i[7:4], b_i[7:4])) << 8);
endmodule

module vedic_mul16_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int HALF_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vedic_mul16_sequencer_if.slave bus
);
  localparam int PROD_W = 2 * DATA_WIDTH;

  if (HALF_WIDTH != 8 || DATA_WIDTH != 2 * HALF_WIDTH) begin : g_bad_width
    $error("vedic_mul16_sequencer: HALF_WIDTH must be 8 and DATA_WIDTH 2*HALF_WIDTH");
  end

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL0 = 3'd1,
    ST_MUL1 = 3'd2,
    ST_MUL2 = 3'd3,
    ST_MUL3 = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [PROD_W-1:0]       acc_q, acc_d;
  logic [PROD_W-1:0]       product_q;
  logic                    out_valid_q, in_ready_q, busy_q;

  logic [HALF_WIDTH-1:0]   core_a, core_b;
  logic [2*HALF_WIDTH-1:0] core_p;
  logic [PROD_W-1:0]       pp_shifted;

  vedic_8_x_8 u_core (
    .a_i (core_a),
    .b_i (core_b),
    .p_o (core_p)
  );

  // Operand-half select and partial-product alignment for the current MUL state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    core_a     = a_q[HALF_WIDTH-1:0];
    core_b     = b_q[HALF_WIDTH-1:0];
    pp_shifted = PROD_W'(core_p);
    unique case (state_q)
      ST_MUL1: begin
        core_a     = a_q[DATA_WIDTH-1:HALF_WIDTH];
        pp_shifted = PROD_W'(core_p) << HALF_WIDTH;
      end
      ST_MUL2: begin
        core_b     = b_q[DATA_WIDTH-1:HALF_WIDTH];
        pp_shifted = PROD_W'(core_p) << HALF_WIDTH;
      end
      ST_MUL3: begin
        core_a     = a_q[DATA_WIDTH-1:HALF_WIDTH];
        core_b     = b_q[DATA_WIDTH-1:HALF_WIDTH];
        pp_shifted = PROD_W'(core_p) << DATA_WIDTH;
      end
      default: ;
    endcase
    acc_d = acc_q + pp_shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else if (bus.clear) begin
      // Abort wins over everything; product and operands are deliberately left alone.
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            acc_q      <= '0;
            state_q    <= ST_MUL0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_MUL0: begin
          acc_q   <= acc_d;
          state_q <= ST_MUL1;
        end
        ST_MUL1: begin
          acc_q   <= acc_d;
          state_q <= ST_MUL2;
        end
        ST_MUL2: begin
          acc_q   <= acc_d;
          state_q <= ST_MUL3;
        end
        ST_MUL3: begin
          acc_q       <= acc_d;
          product_q   <= acc_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          acc_q       <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_vedic_mul16_sequencer.sv
// Self-checking bench for vedic_mul16_sequencer: directed vectors, handshake corner
// sequences, and a randomized regression against a queue-based a*b reference model.
module tb_vedic_mul16_sequencer;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  vedic_mul16_sequencer_if #(.DATA_WIDTH(16)) bus ();

  vedic_mul16_sequencer #(.DATA_WIDTH(16), .HALF_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Presents one operand pair from IDLE and waits (bounded) for the result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input string tag, output int acc_cyc);
    int lat;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    step();
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_product"}, bus.product, exp);
  endtask

  initial begin
    vec_t        vecs[5];
    int          acc_cyc, prev_cyc;
    logic [31:0] held;
    logic [31:0] q[$];
    int          n_acc, n_rcv, budget;
    logic        took;

    vecs[0] = '{16'h1234, 16'h5678, 32'h06260060};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h0000, 16'hABCD, 32'h00000000};
    vecs[3] = '{16'h0100, 16'h00FF, 32'h0000FF00};
    vecs[4] = '{16'hFF00, 16'h00FF, 32'h00FE0100};

    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0;

    // Reset state, observed before any clock edge.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_product",   bus.product,        32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_out_valid", 32'(bus.out_valid), 32'd0);
      check("idle_in_ready",  32'(bus.in_ready),  32'd1);
      check("idle_busy",      32'(bus.busy),      32'd0);
      check("idle_product",   bus.product,        32'd0);
    end

    // Table-driven back-to-back vectors with out_ready held high.
    bus.out_ready = 1'b1;
    prev_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), acc_cyc);
      if (i > 0) check("issue_interval", 32'(acc_cyc - prev_cyc), 32'd6);
      prev_cyc = acc_cyc;
      step();
      check("one_cycle_valid", 32'(bus.out_valid), 32'd0);
      check("back_in_ready",   32'(bus.in_ready),  32'd1);
    end

    // Backpressure: result held, new operands ignored.
    bus.out_ready = 1'b0;
    run_op(16'hBEEF, 16'h1357, ref_mul(16'hBEEF, 16'h1357), "bp", acc_cyc);
    held = ref_mul(16'hBEEF, 16'h1357);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      step();
      check("bp_product",   bus.product,        held);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    run_op(16'd7, 16'd9, 32'd63, "bp_next", acc_cyc);
    step();

    // Abort in MUL2: nothing is delivered, then a clean 3*5.
    bus.a = 16'h1111; bus.b = 16'h2222; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    check("clr_in_ready",  32'(bus.in_ready),  32'd1);
    check("clr_busy",      32'(bus.busy),      32'd0);
    check("clr_product",   bus.product,        32'd63);
    for (int i = 0; i < 8; i++) begin
      step();
      check("clr_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op(16'd3, 16'd5, 32'd15, "clr_next", acc_cyc);
    step();

    // Clear beats in_valid in IDLE.
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.a = 16'd9; bus.b = 16'd9;
    step();
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    check("clr_idle_busy",     32'(bus.busy),     32'd0);
    check("clr_idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Clear in DONE drops the pending result.
    bus.out_ready = 1'b0;
    run_op(16'h00AA, 16'h0055, 32'h00003872, "clr_done", acc_cyc);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.out_ready = 1'b1;
    check("clr_done_valid",   32'(bus.out_valid), 32'd0);
    check("clr_done_ready",   32'(bus.in_ready),  32'd1);
    check("clr_done_product", bus.product,        32'h00003872);
    for (int i = 0; i < 6; i++) begin
      step();
      check("clr_done_quiet", 32'(bus.out_valid), 32'd0);
    end

    // Async reset in MUL1, checked before the next clock edge.
    bus.a = 16'h4321; bus.b = 16'h8765; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_product",   bus.product,        32'd0);
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    check("arst_busy",      32'(bus.busy),      32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("arst_no_valid", 32'(bus.out_valid), 32'd0);
    end

    // Randomized regression against an in-order queue of a*b.
    n_acc = 0; n_rcv = 0; budget = 0;
    bus.in_valid = 1'b0;
    while (n_rcv < 2000 && budget < 60000) begin
      if (!bus.in_valid && n_acc < 2000 && $urandom_range(3) != 0) begin
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(3) != 0);
      took = bus.in_valid && bus.in_ready;
      if (took) begin
        q.push_back(ref_mul(bus.a, bus.b));
        n_acc++;
      end
      check("rand_ready_excl", 32'(bus.in_ready & bus.out_valid), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("rand_spurious", 32'd1, 32'd0);
        else               check("rand_product", bus.product, q.pop_front());
        n_rcv++;
      end
      step();
      budget++;
      if (took) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    check("rand_received", 32'(n_rcv), 32'd2000);
    check("rand_leftover", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
